// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared requester ids and arbiter state encoding for the dmem arbiter.
package rv_mem_pkg;
    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_EXT  = 1'b1;
    typedef enum logic {ARB_UNLOCKED, ARB_LOCKED_M1} arb_state_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: both requester ports plus the dmem side of the arbiter.
interface mem_arbiter_if #(parameter int Width = 32);
    logic             m0_valid, m0_we, m0_ready, m0_rvalid;
    logic [Width-1:0] m0_addr, m0_wdata, m0_rdata;
    logic             m1_valid, m1_we, m1_ready, m1_rvalid, m1_lock;
    logic [Width-1:0] m1_addr, m1_wdata, m1_rdata;
    logic             core_stall, mem_we;
    logic [Width-1:0] mem_addr, mem_wdata, mem_rdata;
    modport slave (
        input  m0_valid, m0_we, m0_addr, m0_wdata, m1_valid, m1_we, m1_addr, m1_wdata, m1_lock, mem_rdata,
        output m0_ready, m0_rvalid, m0_rdata, m1_ready, m1_rvalid, m1_rdata, core_stall, mem_addr, mem_we, mem_wdata
    );
    modport master (
        output m0_valid, m0_we, m0_addr, m0_wdata, m1_valid, m1_we, m1_addr, m1_wdata, m1_lock, mem_rdata,
        input  m0_ready, m0_rvalid, m0_rdata, m1_ready, m1_rvalid, m1_rdata, core_stall, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin picker; force1 restricts the grant to requester 1.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    input  logic       force1,
    output logic [1:0] gnt
);
    always_comb gnt = force1 ? {req[1], 1'b0} : (&req ? (prio ? 2'b10 : 2'b01) : req);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares single-port dmem between the core (m0) and an external master (m1),
// round-robin with an m1 lock for multi-beat transfers and a registered read response.
module mem_arbiter
    import rv_mem_pkg::*;
#(
    parameter int Width = 32
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    arb_state_e       state_q, state_d;
    logic             prio_q, prio_d, rvalid_q, rvalid_d, resp_id_q, resp_id_d;
    logic [Width-1:0] rdata_q, rdata_d;
    logic [1:0]       gnt;
    logic             locked, gnt_we, rd_hs;

    assign locked = state_q == ARB_LOCKED_M1;
    assign gnt_we = gnt[1] ? bus.m1_we : (gnt[0] & bus.m0_we);
    assign rd_hs  = |gnt & ~gnt_we;

    rr_arb2 u_pick (
        .req    ({bus.m1_valid, bus.m0_valid}),
        .prio   (prio_q),
        .force1 (locked),
        .gnt    (gnt)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ARB_UNLOCKED;
            prio_q    <= 1'b0;
            rvalid_q  <= 1'b0;
            resp_id_q <= REQ_CORE;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            rvalid_q  <= rvalid_d;
            resp_id_q <= resp_id_d;
            rdata_q   <= rdata_d;
        end
    end

    // Only an m1 handshake moves the lock; prio flips to the loser of an unlocked grant.
    always_comb begin
        state_d   = gnt[1] ? (bus.m1_lock ? ARB_LOCKED_M1 : ARB_UNLOCKED) : state_q;
        prio_d    = (locked || gnt == 2'b00) ? prio_q : gnt[0];
        rvalid_d  = rd_hs;
        resp_id_d = rd_hs ? gnt[1] : resp_id_q;
        rdata_d   = rd_hs ? bus.mem_rdata : rdata_q;
    end

    always_comb begin
        bus.m0_ready   = gnt[0];
        bus.m1_ready   = gnt[1];
        bus.core_stall = bus.m0_valid & ~gnt[0];
        bus.mem_addr   = gnt[1] ? bus.m1_addr : bus.m0_addr;
        bus.mem_wdata  = gnt[1] ? bus.m1_wdata : bus.m0_wdata;
        bus.mem_we     = gnt_we;
        bus.m0_rvalid  = rvalid_q & (resp_id_q == REQ_CORE);
        bus.m1_rvalid  = rvalid_q & (resp_id_q == REQ_EXT);
        bus.m0_rdata   = rdata_q;
        bus.m1_rdata   = rdata_q;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-port data memory (`dmem`) between the single-cycle RISC-V core and a second master: a program loader, debug or DMA port. It sits between `riscv_single` and `dmem` in the top level, and the core's memory interface becomes requester 0. Arbitration is round-robin, with a lock that lets requester 1 own memory across multi-beat transfers. Read data returns on a registered, one-cycle response pulse, and a stall output lets the core hold its PC while it is denied.

## Interface
Parameters:
- `Width`, 32, data and address width in bits.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `m0_valid`  in  1  core request valid.
- `m0_we`  in  1  core write enable (1 = store, 0 = load).
- `m0_addr`  in  Width  core byte address.
- `m0_wdata`  in  Width  core store data.
- `m0_ready`  out  1  core request accepted this cycle.
- `m0_rvalid`  out  1  core read response valid.
- `m0_rdata`  out  Width  core read data.
- `m1_valid`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_ready`, `m1_rvalid`, `m1_rdata`: same meanings for requester 1.
- `m1_lock`  in  1  sampled with an m1 handshake; holds the grant on m1.
- `core_stall`  out  1  equals `m0_valid & ~m0_ready`.
- `mem_addr`  out  Width  address to `dmem`.
- `mem_we`  out  1  write strobe to `dmem`.
- `mem_wdata`  out  Width  write data to `dmem`.
- `mem_rdata`  in  Width  combinational read data from `dmem`.

## Operation
- **Handshake.** A request is accepted when `mX_valid & mX_ready`. `mX_ready` is combinational from the valids and the current state. At most one ready is high per cycle.
- **Priority pointer `prio`.**
  - 0 favours m0; 1 favours m1.
  - If both requesters are valid, the favoured one is granted.
  - If exactly one is valid, it is granted.
  - After any grant to mX, `prio` points to the other requester. With no grant, `prio` holds.
- **State machine**, two states:
  - UNLOCKED → LOCKED_M1 on an m1 handshake with `m1_lock=1`.
  - LOCKED_M1 → UNLOCKED on an m1 handshake with `m1_lock=0`.
  - In LOCKED_M1, `m0_ready=0` unconditionally. m1 is granted whenever `m1_valid`, and `prio` is not updated.
  - In LOCKED_M1 with `m1_valid=0`, the lock holds and memory is idle.
- **Memory side.**
  - `mem_addr` and `mem_wdata` mux from the granted requester. With no grant they carry m0's values, which keeps the core's combinational path the default.
  - `mem_we = grant & granted_we`. `mem_we` is never high without a handshake.
- **Read response.** On an accepted read by mX, `mem_rdata` is captured into a shared `Width`-bit register and `resp_id=X`. `mX_rvalid` pulses exactly one cycle later. Writes generate no response.
- **Response data hold.** `mX_rdata` holds the last captured value until the next read response. No backpressure on responses.
- **Address passthrough.** Addresses pass unchanged with no width conversion. Alignment is the requester's responsibility.

## Timing
- **Reset values** (`reset=0` at a clock edge):
  - `prio=0`, state UNLOCKED.
  - `m0_rvalid=0`, `m1_rvalid=0`, `m0_rdata=0`, `m1_rdata=0`.
  - Combinational outputs follow the inputs.
- **Reset overriding a request.** Reset asserted in the same cycle as a read handshake suppresses the next-cycle `rvalid`.
- **Reset mid-lock.** Reset clears the lock.
- **Latency.**
  - Grant: 0 cycles.
  - Write commit: at the edge ending the handshake cycle.
  - Read data: 1 cycle after the handshake.
- **Back-to-back reads.** These are permitted, one per cycle. Response N+1 follows response N with no gap.
- **Simultaneous events.**
  - Both valid in UNLOCKED: alternating grants (m0, m1, m0, ...) starting from the current `prio`.
  - An m1 handshake with lock=0 in LOCKED_M1 makes m0 eligible in the next cycle.

## Structure
- Shared package `rv_mem_pkg` holds:
  - `REQ_CORE=0`, `REQ_EXT=1`.
  - The state enum `{ARB_UNLOCKED, ARB_LOCKED_M1}`.
- One sub-module, `rr_arb2`: a 2-way round-robin picker.
  - Inputs: `req[1:0]`, `prio`, `force1`.
  - Outputs: `gnt[1:0]` (one-hot or zero).
- The top of `mem_arbiter` holds the state, `prio`, the response registers and the muxes.
- Top-level integration: when `core_stall` is high, the core must hold its PC and suppress register writeback.

## Test plan
- **Reset:** `reset=0` for 2 cycles with `m1_valid=1` → after release, `prio=0`, both `rvalid=0`, no `mem_we` during reset.
- **Contention:** both requesters issue reads every cycle (m0 to addr 0x10, m1 to 0x20), memory preloaded 0x10→0xAAAA, 0x20→0xBBBB → grants m0, m1, m0, m1. `m0_rvalid` with 0xAAAA and `m1_rvalid` with 0xBBBB alternate, each one cycle after its grant. `core_stall=1` on m1-grant cycles.
- **Lock:** m1 writes 0x100, 0x104, 0x108 with `m1_lock=1,1,0` while `m0_valid=1` → `m0_ready=0` for all three beats; m0 is granted the cycle after the third beat; memory holds the three words.
- **Write then read:** m0 writes 0xDEADBEEF to 0x40, then reads 0x40 → read response 0xDEADBEEF one cycle after the read handshake; no `rvalid` for the write.
- **Idle lock:** in LOCKED_M1, deassert `m1_valid` for 5 cycles with `m0_valid=1` → m0 stays stalled and `mem_we=0`. Then assert `reset=0` → the next cycle grants m0.
